// File: rtl/serial_rx.sv
// -----------------------------------------------------------------------------
// serial_rx
//   Serial frame receiver fed by the synchronized output of the 2-flop input
//   buffer. The line idles high; a frame is one start bit (0), DATA_BITS data
//   bits LSB first, and one stop bit (1). Every bit lasts CLKS_PER_BIT clocks
//   and is sampled at its middle.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in         synchronized serial line, idle = 1
//   data       last correctly framed word, held until the next good frame
//   valid      one-cycle pulse, data updated in this cycle
//   frame_err  one-cycle pulse, stop bit was sampled low
//   busy       high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module serial_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS + 1);

    // Counter value at the sample point: half a bit after the start edge in
    // START, then a full bit period for every following sample.
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO  = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_WAIT  = 3'd4
    } state_t;

    state_t               state_r;
    state_t               state_next_s;
    logic [CNT_W-1:0]     cnt_r;
    logic [IDX_W-1:0]     idx_r;
    logic [DATA_BITS-1:0] shift_r;
    logic [DATA_BITS-1:0] shift_next_s;
    logic                 sample_s;
    logic                 valid_s;
    logic                 err_s;

    // New shift value: sampled bit enters at the MSB so the first bit ends at the LSB.
    generate
        if (DATA_BITS > 1) begin : g_shift_wide
            assign shift_next_s = {in, shift_r[DATA_BITS-1:1]};
        end else begin : g_shift_one
            assign shift_next_s = in;
        end
    endgenerate

    // Sample-point decode: mid start bit in START, one bit period later otherwise.
    always_comb begin
        sample_s = 1'b0;
        case (state_r)
            S_START: sample_s = (cnt_r == HALF_LAST);
            S_DATA:  sample_s = (cnt_r == BIT_LAST);
            S_STOP:  sample_s = (cnt_r == BIT_LAST);
            default: sample_s = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (!in) state_next_s = S_START;
                else     state_next_s = S_IDLE;
            end
            S_START: begin
                // A high line at mid start bit is a glitch, not a frame.
                if (sample_s) state_next_s = in ? S_IDLE : S_DATA;
                else          state_next_s = S_START;
            end
            S_DATA: begin
                if (sample_s && (idx_r == IDX_LAST)) state_next_s = S_STOP;
                else                                 state_next_s = S_DATA;
            end
            S_STOP: begin
                if (sample_s) state_next_s = in ? S_IDLE : S_WAIT;
                else          state_next_s = S_STOP;
            end
            S_WAIT: begin
                // Hold off until the line recovers so a stuck-low line cannot retrigger.
                if (in) state_next_s = S_IDLE;
                else    state_next_s = S_WAIT;
            end
            default: state_next_s = S_IDLE;
        endcase
    end

    // Output decode: result of the stop-bit sample.
    always_comb begin
        valid_s = 1'b0;
        err_s   = 1'b0;
        if ((state_r == S_STOP) && sample_s) begin
            valid_s = in;
            err_s   = ~in;
        end else begin
            valid_s = 1'b0;
            err_s   = 1'b0;
        end
    end

    // Bit-period clock counter; cleared at each sample point and outside a frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= CNT_ZERO;
        end else begin
            case (state_r)
                S_START, S_DATA, S_STOP: cnt_r <= sample_s ? CNT_ZERO : (cnt_r + CNT_ONE);
                default:                 cnt_r <= CNT_ZERO;
            endcase
        end
    end

    // Data bit index and shift register.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_r   <= IDX_ZERO;
            shift_r <= {DATA_BITS{1'b0}};
        end else if ((state_r == S_START) && sample_s) begin
            idx_r   <= IDX_ZERO;
            shift_r <= shift_r;
        end else if ((state_r == S_DATA) && sample_s) begin
            idx_r   <= idx_r + IDX_ONE;
            shift_r <= shift_next_s;
        end else begin
            idx_r   <= idx_r;
            shift_r <= shift_r;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            data      <= {DATA_BITS{1'b0}};
            valid     <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            valid     <= valid_s;
            frame_err <= err_s;
            busy      <= (state_next_s != S_IDLE);
            if (valid_s) data <= shift_r;
            else         data <= data;
        end
    end

endmodule

// File: tb/tb_serial_rx.sv
// -----------------------------------------------------------------------------
// tb_serial_rx
//   Directed bench for serial_rx (CLKS_PER_BIT=16, DATA_BITS=8). Cycle k is
//   counted from T0, the cycle in which the start bit is first driven.
// -----------------------------------------------------------------------------
module tb_serial_rx;

    localparam int CPB = 16;

    logic       clk;
    logic       reset;
    logic       rx_in;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    int n_checks;
    int n_errors;

    int k;
    int nvalid, nerr, nbusy, nboth;
    int first_busy, last_busy, err_k;
    int valid_k_q[$];
    logic [7:0] valid_d_q[$];

    serial_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in        (rx_in),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        k = 0; nvalid = 0; nerr = 0; nbusy = 0;
        first_busy = -1; last_busy = -1; err_k = -1;
        valid_k_q.delete();
        valid_d_q.delete();
    endtask

    // Drive the line for cycle k, advance one clock, then record the outputs of the new cycle.
    task automatic tick(input logic line);
        rx_in = line;
        @(posedge clk);
        #1;
        k++;
        if (valid) begin
            nvalid++;
            valid_k_q.push_back(k);
            valid_d_q.push_back(data);
        end
        if (frame_err) begin
            nerr++;
            err_k = k;
        end
        if (valid && frame_err) nboth++;
        if (busy) begin
            nbusy++;
            if (first_busy < 0) first_busy = k;
            last_busy = k;
        end
    endtask

    function automatic logic frame_line(input logic [7:0] d, input logic stop, input int c);
        int b;
        b = c / CPB;
        if (b == 0)      return 1'b0;
        else if (b <= 8) return d[b-1];
        else             return stop;
    endfunction

    task automatic send(input logic [7:0] d, input logic stop);
        for (int c = 0; c < 10 * CPB; c++) tick(frame_line(d, stop, c));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        nboth    = 0;
        reset    = 1'b1;
        rx_in    = 1'b1;
        clear_mon();

        // Reset and idle line
        for (int i = 0; i < 3; i++) tick(1'b1);
        check_val("rst_data", data, 32'h0);
        check_val("rst_valid", valid, 32'h0);
        check_val("rst_ferr", frame_err, 32'h0);
        check_val("rst_busy", busy, 32'h0);
        reset = 1'b0;
        clear_mon();
        for (int i = 0; i < 20; i++) tick(1'b1);
        check_val("idle_nvalid", nvalid, 32'd0);
        check_val("idle_nerr", nerr, 32'd0);
        check_val("idle_nbusy", nbusy, 32'd0);
        check_val("idle_data", data, 32'h0);

        // Single frame 0xA5
        clear_mon();
        send(8'hA5, 1'b1);
        for (int i = 0; i < 10; i++) tick(1'b1);
        check_val("a5_nvalid", nvalid, 32'd1);
        if (nvalid > 0) begin
            check_val("a5_valid_k", valid_k_q[0], 32'd153);
            check_val("a5_data", valid_d_q[0], 32'hA5);
        end
        check_val("a5_nerr", nerr, 32'd0);
        check_val("a5_first_busy", first_busy, 32'd1);
        check_val("a5_last_busy", last_busy, 32'd152);
        check_val("a5_nbusy", nbusy, 32'd152);
        check_val("a5_data_hold", data, 32'hA5);

        // Back-to-back 0x3C, 0xFF
        clear_mon();
        send(8'h3C, 1'b1);
        send(8'hFF, 1'b1);
        for (int i = 0; i < 20; i++) tick(1'b1);
        check_val("b2b_nvalid", nvalid, 32'd2);
        check_val("b2b_nerr", nerr, 32'd0);
        if (nvalid > 1) begin
            check_val("b2b_k0", valid_k_q[0], 32'd153);
            check_val("b2b_d0", valid_d_q[0], 32'h3C);
            check_val("b2b_k1", valid_k_q[1], 32'd313);
            check_val("b2b_d1", valid_d_q[1], 32'hFF);
        end

        // Framing error 0x55, line stuck low 40 cycles after the frame
        clear_mon();
        send(8'h55, 1'b0);
        for (int i = 0; i < 40; i++) tick(1'b0);
        for (int i = 0; i < 20; i++) tick(1'b1);
        check_val("ferr_nerr", nerr, 32'd1);
        check_val("ferr_k", err_k, 32'd153);
        check_val("ferr_nvalid", nvalid, 32'd0);
        check_val("ferr_data", data, 32'hFF);
        check_val("ferr_last_busy", last_busy, 32'd200);
        check_val("ferr_nbusy", nbusy, 32'd200);

        // Start-bit glitch
        clear_mon();
        for (int i = 0; i < 5; i++) tick(1'b0);
        for (int i = 0; i < 30; i++) tick(1'b1);
        check_val("glitch_nvalid", nvalid, 32'd0);
        check_val("glitch_nerr", nerr, 32'd0);
        check_val("glitch_last_busy", last_busy, 32'd8);

        // Reset in the middle of frame 0x81, then frame 0x42
        clear_mon();
        for (int c = 0; c < 80; c++) tick(frame_line(8'h81, 1'b1, c));
        reset = 1'b1;
        tick(frame_line(8'h81, 1'b1, 80));
        reset = 1'b0;
        check_val("mid_rst_data", data, 32'h0);
        check_val("mid_rst_valid", valid, 32'h0);
        check_val("mid_rst_ferr", frame_err, 32'h0);
        check_val("mid_rst_busy", busy, 32'h0);
        for (int c = 81; c < 160; c++) tick(1'b1);
        check_val("mid_rst_nvalid", nvalid, 32'd0);
        check_val("mid_rst_nerr", nerr, 32'd0);
        clear_mon();
        send(8'h42, 1'b1);
        for (int i = 0; i < 10; i++) tick(1'b1);
        check_val("f42_nvalid", nvalid, 32'd1);
        if (nvalid > 0) begin
            check_val("f42_valid_k", valid_k_q[0], 32'd153);
            check_val("f42_data", valid_d_q[0], 32'h42);
        end
        check_val("f42_nerr", nerr, 32'd0);

        check_val("never_both", nboth, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
